// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - lock-gated raster timing generator (hsync/vsync/de/x/y)
// Starts the raster only after pll_locked has been seen high for LOCK_WAIT synchronized cycles.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int LOCK_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_MAX    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_MAX    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_DE_END = 12'(H_ACTIVE);
  localparam logic [11:0] V_DE_END = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] LW_LAST  = 16'(LOCK_WAIT - 1);
  localparam logic        ACT      = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        sync1, lk;
  logic [15:0] settle_cnt, settle_nxt;
  logic [11:0] x_nxt, y_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= 16'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // The WAIT_LOCK cycle that sees lk counts as the first of the LOCK_WAIT lock cycles.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lk) begin
          settle_nxt = 16'd0;
          state_nxt  = (LOCK_WAIT <= 1) ? RUN : SETTLE;
        end
      end
      SETTLE: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
        end else begin
          settle_nxt = settle_cnt + 16'd1;
          if (settle_nxt >= LW_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lk) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    x_nxt = 12'd0;
    y_nxt = 12'd0;
    if (state == RUN && state_nxt == RUN) begin
      if (x == H_MAX) begin
        x_nxt = 12'd0;
        y_nxt = (y == V_MAX) ? 12'd0 : y + 12'd1;
      end else begin
        x_nxt = x + 12'd1;
        y_nxt = y;
      end
    end
  end

  // Every output is decoded from the same next position so they stay cycle-aligned with x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~ACT;
      vsync       <= ~ACT;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else if (state_nxt == RUN) begin
      x           <= x_nxt;
      y           <= y_nxt;
      de          <= (x_nxt < H_DE_END) && (y_nxt < V_DE_END);
      hsync       <= ((x_nxt >= HS_BEG) && (x_nxt < HS_END)) ? ACT : ~ACT;
      vsync       <= ((y_nxt >= VS_BEG) && (y_nxt < VS_END)) ? ACT : ~ACT;
      line_start  <= (x_nxt == 12'd0);
      frame_start <= (x_nxt == 12'd0) && (y_nxt == 12'd0);
      running     <= 1'b1;
    end else begin
      hsync       <= ~ACT;
      vsync       <= ~ACT;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen on a reduced raster
// Raster: 25 clocks/line (16 active, hsync x=18..21), 13 lines/frame (8 active, vsync y=9..10).
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = 25, VT = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        hsync, vsync, de, line_start, frame_start, running;
  logic [11:0] x, y;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .LOCK_WAIT(16)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic d,
                                       input logic ls, input logic fs, input logic rn,
                                       input logic [11:0] xx, input logic [11:0] yy);
    return {2'b00, hs, vs, d, ls, fs, rn, xx, yy};
  endfunction

  function automatic logic [31:0] idle_vec();
    return pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(hsync, vsync, de, line_start, frame_start, running, x, y);
  endfunction

  initial begin
    int fs_cnt, ls_cnt, de_cnt, hs_low, vs_low;
    int ex, ey;
    logic ehs, evs, ede;
    logic found;

    rst = 1'b1;
    pll_locked = 1'b1;
    tick(2);
    check("reset_state", dut_vec(), idle_vec());

    // Lock startup: running rises on the 18th clock after release.
    rst = 1'b0;
    tick(17);
    check("start_17_idle", dut_vec(), idle_vec());
    tick(1);
    check("start_18_run", dut_vec(), pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 12'd0));

    // Two full frames against an index-based raster model.
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_low = 0; vs_low = 0;
    for (int t = 0; t < 2 * HT * VT; t++) begin
      ex  = t % HT;
      ey  = (t / HT) % VT;
      ehs = !(ex >= 18 && ex < 22);
      evs = !(ey >= 9 && ey < 11);
      ede = (ex < 16) && (ey < 8);
      check("raster", dut_vec(),
            pack(ehs, evs, ede, ex == 0, ex == 0 && ey == 0, 1'b1, 12'(ex), 12'(ey)));
      fs_cnt += int'(frame_start);
      ls_cnt += int'(line_start);
      de_cnt += int'(de);
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      tick(1);
    end
    check("frame_period", {frame_start, x, y}, {1'b1, 12'd0, 12'd0});
    check("frame_count", fs_cnt, 2);
    check("line_count", ls_cnt, 2 * VT);
    check("de_clocks", de_cnt, 2 * VA * HA);
    check("hsync_clocks", hs_low, 2 * VT * HS);
    check("vsync_clocks", vs_low, 2 * VS * HT);

    // Lock loss mid-line at (10,5).
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      if (x == 12'd10 && y == 12'd5) found = 1'b1;
      else tick(1);
    end
    check("find_pos", found, 1'b1);
    pll_locked = 1'b0;
    tick(2);
    check("loss_still_run", {running, x, y}, {1'b1, 12'd12, 12'd5});
    tick(1);
    check("loss_idle", dut_vec(), idle_vec());
    tick(5);
    check("loss_stays_idle", dut_vec(), idle_vec());
    pll_locked = 1'b1;
    tick(17);
    check("relock_17_idle", running, 1'b0);
    tick(1);
    check("relock_18_run", dut_vec(), pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 12'd0));

    // Asynchronous reset between edges inside the active area at (5,1).
    tick(HT + 5);
    check("pre_rst_active", {de, running, x, y}, {1'b1, 1'b1, 12'd5, 12'd1});
    #2 rst = 1'b1;
    #1 check("async_rst", dut_vec(), idle_vec());
    tick(1);
    rst = 1'b0;

    // One-cycle lock glitch while the settle counter is at 10.
    tick(11);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(6);
    check("glitch_18_idle", running, 1'b0);
    tick(11);
    check("glitch_29_idle", running, 1'b0);
    tick(1);
    check("glitch_30_run", {running, frame_start, x, y}, {1'b1, 1'b1, 12'd0, 12'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
